mc_control_fsm: RTL and testbench
=================================

Name: mc_control_fsm

Overview:
- Multi-cycle control sequencer for the MIPS-subset datapath (RTYPE ADD/SUB/AND/OR, ADDI, LW, SW, BEQ, J).
- Replaces single-cycle combinational control. Instruction execution is split into fetch, decode, execute, memory and writeback states.
- Adds a variable-latency memory req/ready handshake, a memory timeout trap, run/idle gating and a retired-instruction counter.
- Drives the PC, IR, register file, ALU-mux and memory control of the datapath.

Parameters:
- MEM_TIMEOUT, 15, maximum cycles mem_req may wait for mem_ready before trapping; 0 disables the timeout.
- CNT_WIDTH, 16, width of retire_count.
- INSTR_BYTES, 4, PC increment selected by alu_src_b=01. The datapath applies it; it is exported only as a constant.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- run  in  1  1 allows new instruction fetches.
- instr  in  32  current IR contents (Instruction).
- mem_ready  in  1  memory completes the current request this cycle.
- alu_zero  in  1  ALU zero flag.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if alu_zero.
- pc_src  out  2  00 ALU result, 01 ALUOut register, 10 jump target.
- ir_write  out  1  IR load from memory data.
- mem_req  out  1  memory request.
- mem_we  out  1  write request (valid with mem_req).
- iord  out  1  0 address=PC, 1 address=ALUOut.
- reg_write  out  1  register-file write.
- reg_dst  out  1  0 rt, 1 rd.
- mem_to_reg  out  1  0 ALUOut, 1 memory data register.
- alu_src_a  out  1  0 PC, 1 A register.
- alu_src_b  out  2  00 B, 01 INSTR_BYTES, 10 sign-extended imm, 11 sign-extended imm<<2.
- alu_op  out  2  00 add, 01 sub, 10 decode funct.
- state_o  out  4  current state encoding.
- instr_retired  out  1  one-cycle pulse on an instruction's final cycle.
- retire_count  out  CNT_WIDTH  retired instructions, wraps modulo 2^CNT_WIDTH.
- trap  out  1  sticky: illegal opcode or funct, or memory timeout.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, retire_count=0, trap=0, timer=0. All control outputs are 0.
- Outputs are Moore decodes of state. Exception: in FETCH, ir_write and pc_write equal mem_ready.
- Any output not listed for a state is 0.
- IDLE: if run=1 go to FETCH, otherwise stay.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00.
  - When mem_ready=1: ir_write=1, pc_write=1, pc_src=00, go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Dispatch on instr[31:26]:
  - RTYPE with funct in {ADD, SUB, AND, OR} -> EXEC_R.
  - ADDI -> EXEC_I.
  - LW or SW -> ADDR.
  - BEQ -> BRANCH.
  - J -> JUMP.
  - Anything else -> TRAP.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10 -> WB_R.
- WB_R: reg_write=1, reg_dst=1, mem_to_reg=0; retire.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=00 -> WB_I.
- WB_I: reg_write=1, reg_dst=0, mem_to_reg=0; retire.
- ADDR: same ALU controls as EXEC_I. LW -> MEM_RD, SW -> MEM_WR.
- MEM_RD: mem_req=1, iord=1. On mem_ready go to WB_MEM.
- WB_MEM: reg_write=1, reg_dst=0, mem_to_reg=1; retire.
- MEM_WR: mem_req=1, mem_we=1, iord=1. On mem_ready, retire.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_src=01; retire.
- JUMP: pc_write=1, pc_src=10; retire.
- Retire: instr_retired=1 in that cycle and retire_count increments. Next state is FETCH if run=1, else IDLE.
- run is sampled only in IDLE and at retire. Deasserting run mid-instruction lets the instruction complete.
- Handshake:
  - mem_req stays high and the address controls stay stable until the cycle mem_ready=1.
  - mem_ready while mem_req=0 is ignored.
  - Zero-wait response (ready in the first request cycle) is legal: the memory state lasts 1 cycle.
- Timeout:
  - Timer clears on entry to FETCH, MEM_RD or MEM_WR, and increments each waiting cycle with mem_ready=0.
  - When timer == MEM_TIMEOUT-1 and mem_ready=0, go to TRAP.
  - mem_ready in that same cycle wins: no trap.
- TRAP: trap=1, all writes and requests 0, absorbing until reset. No retire pulse.

Decomposition:
- Shared package additions:
  - McState enum (4-bit): IDLE, FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEM_RD, MEM_WR, WB_R, WB_I, WB_MEM, BRANCH, JUMP, TRAP.
  - AluOp, PcSrc and AluSrcB enums.
  - INSTR_BYTES constant.
- Reuse the existing OpCode, Funct and RType/IType types.
- Sub-module mc_mem_timer: parametrised clear/increment counter with an expired flag.

Test Plan:
- Reset mid-MEM_RD (reset_n low asynchronously) -> state_o=IDLE, all outputs 0, retire_count=0 immediately, before the next clock edge.
- run=1, ADD r3,r1,r2 (0x00221820), mem_ready always 1 -> states FETCH, DECODE, EXEC_R, WB_R. instr_retired in cycle 4 with reg_write=1, reg_dst=1. retire_count=1.
- LW (0x8C220004) with mem_ready delayed 3 cycles on the data access -> MEM_RD holds mem_req=1, iord=1 for 4 cycles. WB_MEM asserts mem_to_reg=1. Retire, no trap.
- MEM_TIMEOUT=4, fetch with mem_ready never asserted -> trap=1 after 4 FETCH cycles, state TRAP, held for 20+ cycles. mem_ready=1 on exactly the 4th cycle -> no trap.
- Opcode 0x3F, or RTYPE with funct 0x27 -> DECODE to TRAP, no reg_write, no retire pulse.
- BEQ with alu_zero=1, then J, with run deasserted during the J -> pc_write_cond=1, pc_src=01; J completes with pc_src=10. Then IDLE; retire_count reaches 0 after 2^CNT_WIDTH retires (wrap check with CNT_WIDTH=2).

Source files
------------

// File: rtl/mc_control_fsm_pkg.sv
// mc_control_fsm_pkg: shared MIPS-subset opcode/funct/instruction types, sequencer state and control-field encodings
package mc_control_fsm_pkg;
  localparam int INSTR_BYTES = 4;
  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_BEQ   = 6'h04,
    OP_ADDI  = 6'h08,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2b
  } OpCode;
  typedef enum logic [5:0] {
    FN_ADD = 6'h20,
    FN_SUB = 6'h22,
    FN_AND = 6'h24,
    FN_OR  = 6'h25
  } Funct;
  typedef struct packed {
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } RType;
  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
  } IType;
  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEM_RD, MEM_WR,
    WB_R, WB_I, WB_MEM, BRANCH, JUMP, TRAP
  } McState;
  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_FUNCT} AluOp;
  typedef enum logic [1:0] {PC_ALU, PC_ALUOUT, PC_JUMP} PcSrc;
  typedef enum logic [1:0] {SRCB_B, SRCB_INSTR, SRCB_IMM, SRCB_IMM_SH2} AluSrcB;
  function automatic McState dispatch(input logic [5:0] op, input logic [5:0] funct);
    case (op)
      OP_RTYPE: return (funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR}) ? EXEC_R : TRAP;
      OP_ADDI:  return EXEC_I;
      OP_LW,
      OP_SW:    return ADDR;
      OP_BEQ:   return BRANCH;
      OP_J:     return JUMP;
      default:  return TRAP;
    endcase
  endfunction
endpackage

// File: rtl/mc_control_fsm_mem_timer.sv
// mc_mem_timer: wait-cycle counter (clk, reset_n, clear, inc) raising expired on its last allowed cycle; TIMEOUT=0 never expires
module mc_mem_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic inc,
  output logic expired
);
  localparam int W = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  logic [W-1:0] count;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) count <= '0;
    else if (clear) count <= '0;
    else if (inc) count <= count + W'(1);
  assign expired = (TIMEOUT != 0) && (count == W'(TIMEOUT - 1));
endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle MIPS-subset sequencer; in: run, instr, mem_ready, alu_zero; out: datapath controls, state_o, retire pulse/count, sticky trap
module mc_control_fsm
  import mc_control_fsm_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 run,
  input  logic [31:0]          instr,
  input  logic                 mem_ready,
  input  logic                 alu_zero,
  output logic                 pc_write,
  output logic                 pc_write_cond,
  output logic [1:0]           pc_src,
  output logic                 ir_write,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 iord,
  output logic                 reg_write,
  output logic                 reg_dst,
  output logic                 mem_to_reg,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic [3:0]           state_o,
  output logic                 instr_retired,
  output logic [CNT_WIDTH-1:0] retire_count,
  output logic                 trap
);
  McState state;
  RType   ir;
  logic   waiting, expired, retire, fetched, unused_bits;
  assign ir          = instr;
  assign unused_bits = ^{ir.rs, ir.rt, ir.rd, ir.shamt, alu_zero};
  assign waiting     = (state inside {FETCH, MEM_RD, MEM_WR}) && !mem_ready;
  assign fetched     = state == FETCH && mem_ready;
  assign retire      = (state inside {WB_R, WB_I, WB_MEM, BRANCH, JUMP}) || (state == MEM_WR && mem_ready);
  mc_mem_timer #(.TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (!waiting),
    .inc     (waiting),
    .expired (expired)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state        <= IDLE;
      retire_count <= '0;
    end else begin
      if (retire) retire_count <= retire_count + CNT_WIDTH'(1);
      case (state)
        IDLE:    state <= run ? FETCH : IDLE;
        FETCH:   state <= mem_ready ? DECODE : expired ? TRAP : FETCH;
        DECODE:  state <= dispatch(ir.op, ir.funct);
        EXEC_R:  state <= WB_R;
        EXEC_I:  state <= WB_I;
        ADDR:    state <= (ir.op == OP_LW) ? MEM_RD : MEM_WR;
        MEM_RD:  state <= mem_ready ? WB_MEM : expired ? TRAP : MEM_RD;
        MEM_WR:  state <= mem_ready ? (run ? FETCH : IDLE) : expired ? TRAP : MEM_WR;
        TRAP:    state <= TRAP;
        default: state <= retire ? (run ? FETCH : IDLE) : TRAP;
      endcase
    end
  assign state_o       = state;
  assign pc_write      = fetched || state == JUMP;
  assign pc_write_cond = state == BRANCH;
  assign pc_src        = state == BRANCH ? PC_ALUOUT : state == JUMP ? PC_JUMP : PC_ALU;
  assign ir_write      = fetched;
  assign mem_req       = state inside {FETCH, MEM_RD, MEM_WR};
  assign mem_we        = state == MEM_WR;
  assign iord          = state inside {MEM_RD, MEM_WR};
  assign reg_write     = state inside {WB_R, WB_I, WB_MEM};
  assign reg_dst       = state == WB_R;
  assign mem_to_reg    = state == WB_MEM;
  assign alu_src_a     = state inside {EXEC_R, EXEC_I, ADDR, BRANCH};
  assign alu_src_b     = state == FETCH ? SRCB_INSTR : state == DECODE ? SRCB_IMM_SH2 :
                         (state inside {EXEC_I, ADDR}) ? SRCB_IMM : SRCB_B;
  assign alu_op        = state == EXEC_R ? ALU_FUNCT : state == BRANCH ? ALU_SUB : ALU_ADD;
  assign instr_retired = retire;
  assign trap          = state == TRAP;
endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: directed-vector bench with a retire-event scoreboard for mc_control_fsm
module tb_mc_control_fsm;
  localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_EXEC_R = 4'd3,
                         S_EXEC_I = 4'd4, S_ADDR = 4'd5, S_MEM_RD = 4'd6, S_MEM_WR = 4'd7,
                         S_WB_R = 4'd8, S_WB_I = 4'd9, S_WB_MEM = 4'd10, S_BRANCH = 4'd11,
                         S_JUMP = 4'd12, S_TRAP = 4'd13;
  logic        clk, reset_n, run, mem_ready, alu_zero;
  logic [31:0] instr;
  logic        pc_write, pc_write_cond, ir_write, mem_req, mem_we, iord;
  logic        reg_write, reg_dst, mem_to_reg, alu_src_a, instr_retired, trap;
  logic [1:0]  pc_src, alu_src_b, alu_op, retire_count;
  logic [3:0]  state_o;
  mc_control_fsm #(.MEM_TIMEOUT(4), .CNT_WIDTH(2)) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .instr(instr), .mem_ready(mem_ready),
    .alu_zero(alu_zero), .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src),
    .ir_write(ir_write), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .state_o(state_o), .instr_retired(instr_retired),
    .retire_count(retire_count), .trap(trap)
  );
  typedef struct {
    string      name;
    logic [13:0] v;
  } exp_t;
  exp_t        sb[$];
  exp_t        mon_e;
  int          n_vec = 0, n_err = 0;
  logic        nrun;
  logic [31:0] ninstr;
  logic [13:0] snap;
  logic [17:0] all_ctl;
  function automatic logic [13:0] pack(input logic [3:0] st, input logic rw, rd, m2r, pw, pwc,
                                       input logic [1:0] ps, input logic we, input logic [1:0] cnt);
    return {st, rw, rd, m2r, pw, pwc, ps, we, cnt};
  endfunction
  assign snap    = pack(state_o, reg_write, reg_dst, mem_to_reg, pc_write, pc_write_cond, pc_src, mem_we, retire_count);
  assign all_ctl = {pc_write, pc_write_cond, pc_src, ir_write, mem_req, mem_we, iord, reg_write,
                    reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, instr_retired, trap};
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic cyc(input logic rdy, input logic [3:0] st, input string name);
    @(posedge clk);
    #1;
    mem_ready = rdy;
    run       = nrun;
    instr     = ninstr;
    @(negedge clk);
    chk({name, "_state"}, 32'(state_o), 32'(st));
  endtask
  task automatic push(input string name, input logic [13:0] v);
    sb.push_back('{name: name, v: v});
  endtask
  task automatic release_rst();
    @(posedge clk);
    #1;
    reset_n   = 1'b1;
    run       = nrun;
    instr     = ninstr;
    mem_ready = 1'b0;
  endtask
  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_n   = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    chk("reset_clears_trap", 32'(trap), 32'd0);
    release_rst();
  endtask
  always @(negedge clk)
    if (reset_n && instr_retired) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_retire: state %0d, expected no retire", state_o);
      end else begin
        mon_e = sb.pop_front();
        chk(mon_e.name, 32'(snap), 32'(mon_e.v));
      end
    end
  initial begin
    reset_n = 1'b0; run = 1'b0; mem_ready = 1'b0; alu_zero = 1'b0; instr = '0;
    nrun = 1'b1; ninstr = 32'h00221820;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 32'(state_o), 32'(S_IDLE));
    chk("reset_ctl", 32'(all_ctl), 32'd0);
    chk("reset_cnt", 32'(retire_count), 32'd0);
    reset_n = 1'b1; run = 1'b1; instr = ninstr; mem_ready = 1'b1;
    cyc(1'b1, S_FETCH, "add_fetch");
    chk("add_fetch_ctl", 32'({pc_write, ir_write, mem_req, iord, alu_src_b}), 32'b1110_01);
    cyc(1'b1, S_DECODE, "add_decode");
    chk("add_decode_srcb", 32'(alu_src_b), 32'd3);
    cyc(1'b1, S_EXEC_R, "add_exec");
    chk("add_exec_alu", 32'({alu_src_a, alu_src_b, alu_op}), 32'b1_00_10);
    push("add_retire", pack(S_WB_R, 1, 1, 0, 0, 0, 2'b00, 0, 2'd0));
    cyc(1'b1, S_WB_R, "add_wb");
    ninstr = 32'h8C220004;
    cyc(1'b1, S_FETCH, "lw_fetch");
    chk("add_cnt", 32'(retire_count), 32'd1);
    cyc(1'b1, S_DECODE, "lw_decode");
    cyc(1'b0, S_ADDR, "lw_addr");
    chk("lw_addr_alu", 32'({alu_src_a, alu_src_b, alu_op, mem_req}), 32'b1_10_00_0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, S_MEM_RD, "lw_wait");
      chk("lw_wait_req", 32'({mem_req, iord, mem_we}), 32'b110);
    end
    cyc(1'b1, S_MEM_RD, "lw_ready");
    chk("lw_ready_req", 32'({mem_req, iord}), 32'b11);
    push("lw_retire", pack(S_WB_MEM, 1, 0, 1, 0, 0, 2'b00, 0, 2'd1));
    cyc(1'b1, S_WB_MEM, "lw_wb");
    chk("lw_no_trap", 32'(trap), 32'd0);
    ninstr = 32'h10220003; alu_zero = 1'b1;
    cyc(1'b1, S_FETCH, "beq_fetch");
    cyc(1'b1, S_DECODE, "beq_decode");
    push("beq_retire", pack(S_BRANCH, 0, 0, 0, 0, 1, 2'b01, 0, 2'd2));
    cyc(1'b1, S_BRANCH, "beq_branch");
    chk("beq_alu", 32'({alu_src_a, alu_src_b, alu_op}), 32'b1_00_01);
    ninstr = 32'h08000010;
    cyc(1'b1, S_FETCH, "j_fetch");
    cyc(1'b1, S_DECODE, "j_decode");
    nrun = 1'b0;
    push("j_retire", pack(S_JUMP, 0, 0, 0, 1, 0, 2'b10, 0, 2'd3));
    cyc(1'b1, S_JUMP, "j_jump");
    cyc(1'b1, S_IDLE, "j_to_idle");
    chk("cnt_wrap", 32'(retire_count), 32'd0);
    cyc(1'b1, S_IDLE, "idle_hold");
    chk("idle_ctl", 32'(all_ctl), 32'd0);
    nrun = 1'b1; ninstr = 32'hAC220008;
    cyc(1'b1, S_IDLE, "sw_run");
    cyc(1'b1, S_FETCH, "sw_fetch");
    cyc(1'b1, S_DECODE, "sw_decode");
    cyc(1'b0, S_ADDR, "sw_addr");
    push("sw_retire", pack(S_MEM_WR, 0, 0, 0, 0, 0, 2'b00, 1, 2'd0));
    cyc(1'b1, S_MEM_WR, "sw_mem");
    chk("sw_req", 32'({mem_req, mem_we, iord}), 32'b111);
    ninstr = 32'h20210005;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, S_FETCH, "addi_fetch_wait");
      chk("addi_fetch_wait_wr", 32'({ir_write, pc_write, mem_req}), 32'b001);
    end
    cyc(1'b1, S_FETCH, "addi_fetch_4th");
    chk("addi_fetch_4th_wr", 32'({ir_write, pc_write}), 32'b11);
    cyc(1'b1, S_DECODE, "addi_decode");
    cyc(1'b1, S_EXEC_I, "addi_exec");
    chk("addi_exec_alu", 32'({alu_src_a, alu_src_b, alu_op}), 32'b1_10_00);
    push("addi_retire", pack(S_WB_I, 1, 0, 0, 0, 0, 2'b00, 0, 2'd1));
    cyc(1'b1, S_WB_I, "addi_wb");
    ninstr = 32'h8C220004;
    cyc(1'b1, S_FETCH, "lw2_fetch");
    cyc(1'b1, S_DECODE, "lw2_decode");
    cyc(1'b0, S_ADDR, "lw2_addr");
    cyc(1'b0, S_MEM_RD, "lw2_mem");
    cyc(1'b0, S_MEM_RD, "lw2_mem");
    chk("pre_reset_cnt", 32'(retire_count), 32'd2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_state", 32'(state_o), 32'(S_IDLE));
    chk("async_reset_ctl", 32'(all_ctl), 32'd0);
    chk("async_reset_cnt", 32'(retire_count), 32'd0);
    ninstr = 32'h00000000;
    release_rst();
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, S_FETCH, "to_fetch");
      chk("to_no_trap_yet", 32'(trap), 32'd0);
    end
    cyc(1'b0, S_TRAP, "to_trap");
    chk("to_trap_flag", 32'(trap), 32'd1);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, S_TRAP, "to_hold");
      chk("to_hold_ctl", 32'({trap, mem_req, reg_write, pc_write, ir_write}), 32'b10000);
    end
    ninstr = 32'hFC000000;
    do_reset();
    cyc(1'b1, S_FETCH, "bad_op_fetch");
    cyc(1'b1, S_DECODE, "bad_op_decode");
    cyc(1'b1, S_TRAP, "bad_op_trap");
    chk("bad_op_ctl", 32'({reg_write, instr_retired, trap}), 32'b001);
    cyc(1'b1, S_TRAP, "bad_op_hold");
    ninstr = 32'h00221827;
    do_reset();
    cyc(1'b1, S_FETCH, "bad_fn_fetch");
    cyc(1'b1, S_DECODE, "bad_fn_decode");
    cyc(1'b1, S_TRAP, "bad_fn_trap");
    chk("bad_fn_ctl", 32'({reg_write, instr_retired, trap}), 32'b001);
    chk("bad_fn_cnt", 32'(retire_count), 32'd0);
    repeat (2) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
